// File: rtl/update_scheduler.sv
// Serialises seed loads, cell toggles and generation steps onto the board engine
// with a start/done handshake, and keeps the generation counter for the display.
module update_scheduler #(
   parameter int LOG_MAX_SPEED  = 4,
   parameter int LOG_BOARD_SIZE = 6,
   parameter int LOG_NUM_SEED   = 2,
   parameter int GEN_WIDTH      = 16
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      frame_in,
   input  logic [LOG_MAX_SPEED-1:0]  speed_in,
   input  logic                      click_in,
   input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
   input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
   input  logic                      seed_en_in,
   input  logic [LOG_NUM_SEED-1:0]   seed_idx_in,
   input  logic                      done_in,
   output logic                      step_out,
   output logic                      toggle_out,
   output logic [LOG_BOARD_SIZE-1:0] toggle_x_out,
   output logic [LOG_BOARD_SIZE-1:0] toggle_y_out,
   output logic                      seed_load_out,
   output logic [LOG_NUM_SEED-1:0]   seed_idx_out,
   output logic                      busy_out,
   output logic [GEN_WIDTH-1:0]      gen_count_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_SEED,
      S_WAIT_TOGGLE,
      S_WAIT_STEP
   } state_t;

   localparam logic [LOG_MAX_SPEED:0] FULL_PERIOD = {1'b1, {LOG_MAX_SPEED{1'b0}}};

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [LOG_MAX_SPEED-1:0]  r_fcnt;
   logic                      r_step_pend;
   logic                      r_click_pend;
   logic                      r_seed_pend;
   logic                      r_seed_en_q;
   logic [LOG_BOARD_SIZE-1:0] r_click_x;
   logic [LOG_BOARD_SIZE-1:0] r_click_y;
   logic [LOG_NUM_SEED-1:0]   r_seed_idx;

   logic [LOG_MAX_SPEED:0]    w_period;
   logic [LOG_MAX_SPEED:0]    w_fcnt_inc;
   logic                      w_hold;
   logic                      w_step_fire;
   logic                      w_seed_rise;
   logic                      w_grant_seed;
   logic                      w_grant_toggle;
   logic                      w_grant_step;

   assign w_period    = FULL_PERIOD - {1'b0, speed_in};
   assign w_fcnt_inc  = {1'b0, r_fcnt} + {{LOG_MAX_SPEED{1'b0}}, 1'b1};
   assign w_hold      = (speed_in == '0) || seed_en_in;
   assign w_step_fire = frame_in && !w_hold && (w_fcnt_inc >= w_period);
   assign w_seed_rise = seed_en_in && !r_seed_en_q;

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_seed   = 1'b0;
      w_grant_toggle = 1'b0;
      w_grant_step   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_seed_pend) begin
               w_grant_seed = 1'b1;
               w_state_nxt  = S_WAIT_SEED;
            end else if (r_click_pend) begin
               w_grant_toggle = 1'b1;
               w_state_nxt    = S_WAIT_TOGGLE;
            end else if (r_step_pend) begin
               w_grant_step = 1'b1;
               w_state_nxt  = S_WAIT_STEP;
            end
         end
         default: begin
            if (done_in) w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Pending requests live in staging registers; the visible capture outputs are
   // loaded only at grant so they stay stable for the whole operation.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state       <= S_IDLE;
         r_fcnt        <= '0;
         r_step_pend   <= 1'b0;
         r_click_pend  <= 1'b0;
         r_seed_pend   <= 1'b0;
         r_seed_en_q   <= 1'b0;
         r_click_x     <= '0;
         r_click_y     <= '0;
         r_seed_idx    <= '0;
         step_out      <= 1'b0;
         toggle_out    <= 1'b0;
         seed_load_out <= 1'b0;
         busy_out      <= 1'b0;
         toggle_x_out  <= '0;
         toggle_y_out  <= '0;
         seed_idx_out  <= '0;
         gen_count_out <= '0;
      end else begin
         r_state       <= w_state_nxt;
         busy_out      <= (w_state_nxt != S_IDLE);
         step_out      <= w_grant_step;
         toggle_out    <= w_grant_toggle;
         seed_load_out <= w_grant_seed;
         r_seed_en_q   <= seed_en_in;

         if (frame_in) begin
            if (w_hold || w_step_fire) r_fcnt <= '0;
            else                       r_fcnt <= w_fcnt_inc[LOG_MAX_SPEED-1:0];
         end

         r_step_pend  <= w_step_fire || (r_step_pend && !w_grant_step);
         r_click_pend <= click_in || (r_click_pend && !w_grant_toggle);
         r_seed_pend  <= w_seed_rise || (r_seed_pend && !w_grant_seed);

         if (click_in && (!r_click_pend || w_grant_toggle)) begin
            r_click_x <= cursor_x_in;
            r_click_y <= cursor_y_in;
         end
         if (w_seed_rise && (!r_seed_pend || w_grant_seed)) r_seed_idx <= seed_idx_in;

         if (w_grant_toggle) begin
            toggle_x_out <= r_click_x;
            toggle_y_out <= r_click_y;
         end
         if (w_grant_seed) seed_idx_out <= r_seed_idx;

         if (done_in && (r_state == S_WAIT_STEP)) gen_count_out <= gen_count_out + GEN_WIDTH'(1);
         else if (done_in && (r_state == S_WAIT_SEED)) gen_count_out <= '0;
      end
   end

endmodule

// File: tb/tb_update_scheduler.sv
// Directed-vector bench for update_scheduler: rates, arbitration, click capture,
// seed mode and mid-operation reset.
module tb_update_scheduler;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic       frame_in = 1'b0;
   logic [3:0] speed_in = '0;
   logic       click_in = 1'b0;
   logic [5:0] cursor_x_in = '0;
   logic [5:0] cursor_y_in = '0;
   logic       seed_en_in = 1'b0;
   logic [1:0] seed_idx_in = '0;
   logic       done_in = 1'b0;
   logic       step_out;
   logic       toggle_out;
   logic [5:0] toggle_x_out;
   logic [5:0] toggle_y_out;
   logic       seed_load_out;
   logic [1:0] seed_idx_out;
   logic       busy_out;
   logic [15:0] gen_count_out;

   int checks = 0;
   int passed = 0;

   update_scheduler #(
      .LOG_MAX_SPEED(4), .LOG_BOARD_SIZE(6), .LOG_NUM_SEED(2), .GEN_WIDTH(16)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in), .speed_in(speed_in),
      .click_in(click_in), .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in),
      .seed_en_in(seed_en_in), .seed_idx_in(seed_idx_in), .done_in(done_in),
      .step_out(step_out), .toggle_out(toggle_out), .toggle_x_out(toggle_x_out),
      .toggle_y_out(toggle_y_out), .seed_load_out(seed_load_out),
      .seed_idx_out(seed_idx_out), .busy_out(busy_out), .gen_count_out(gen_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_frame();
      frame_in = 1'b1;
      tick();
      frame_in = 1'b0;
   endtask

   task automatic engine_done();
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
   endtask

   task automatic do_reset();
      frame_in = 0; click_in = 0; seed_en_in = 0; done_in = 0; speed_in = 0;
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] got;
      do_reset();
      got = {step_out, toggle_out, seed_load_out, busy_out, toggle_x_out, toggle_y_out, seed_idx_out};
      checks++;
      if (got !== 32'd0) $display("FAIL reset_outputs got %h expected 0", got);
      else passed++;
      checks++;
      if (gen_count_out !== 16'd0) $display("FAIL reset_gen got %0d expected 0", gen_count_out);
      else passed++;
   endtask

   task automatic test_speed_max();
      int nbusy;
      do_reset();
      speed_in = 4'd15;
      for (int i = 0; i < 4; i++) begin
         pulse_frame();
         tick();
         checks++;
         if ({step_out, busy_out} !== 2'b11) $display("FAIL p1_step%0d got %b expected 11", i, {step_out, busy_out});
         else passed++;
         nbusy = 1;
         tick(); nbusy += int'(busy_out);
         tick(); nbusy += int'(busy_out);
         done_in = 1'b1;
         tick(); nbusy += int'(busy_out);
         done_in = 1'b0;
         checks++;
         if (nbusy != 3) $display("FAIL p1_busy%0d got %0d expected 3", i, nbusy);
         else passed++;
      end
      checks++;
      if (gen_count_out !== 16'd4) $display("FAIL p1_gen got %0d expected 4", gen_count_out);
      else passed++;
   endtask

   task automatic test_period4();
      int nsteps;
      logic exp_step;
      do_reset();
      speed_in = 4'd12;
      for (int i = 0; i < 12; i++) begin
         pulse_frame();
         tick();
         exp_step = ((i % 4) == 3);
         checks++;
         if (step_out !== exp_step) $display("FAIL p4_frame%0d got %b expected %b", i + 1, step_out, exp_step);
         else passed++;
         if (step_out) engine_done();
      end
      checks++;
      if (gen_count_out !== 16'd3) $display("FAIL p4_gen got %0d expected 3", gen_count_out);
      else passed++;
      speed_in = 4'd0;
      nsteps = 0;
      for (int i = 0; i < 12; i++) begin
         pulse_frame(); nsteps += int'(step_out);
         tick();        nsteps += int'(step_out);
      end
      checks++;
      if (nsteps != 0) $display("FAIL paused_steps got %0d expected 0", nsteps);
      else passed++;
   endtask

   task automatic test_priority();
      do_reset();
      speed_in = 4'd15;
      pulse_frame();
      tick();
      checks++;
      if (step_out !== 1'b1) $display("FAIL prio_first_step got %b expected 1", step_out);
      else passed++;
      pulse_frame();
      click_in = 1'b1; cursor_x_in = 6'd5; cursor_y_in = 6'd9;
      seed_en_in = 1'b1; seed_idx_in = 2'd2;
      tick();
      click_in = 1'b0; cursor_x_in = 6'd7; cursor_y_in = 6'd7; seed_idx_in = 2'd0;
      engine_done();
      tick();
      checks++;
      if ({seed_load_out, toggle_out, step_out, seed_idx_out} !== 5'b10010)
         $display("FAIL prio_seed got %b expected 10010", {seed_load_out, toggle_out, step_out, seed_idx_out});
      else passed++;
      engine_done();
      tick();
      checks++;
      if ({seed_load_out, toggle_out, step_out, toggle_x_out, toggle_y_out} !== {3'b010, 6'd5, 6'd9})
         $display("FAIL prio_toggle got %b_%0d_%0d expected 010_5_9",
                  {seed_load_out, toggle_out, step_out}, toggle_x_out, toggle_y_out);
      else passed++;
      engine_done();
      tick();
      checks++;
      if ({seed_load_out, toggle_out, step_out} !== 3'b001)
         $display("FAIL prio_step got %b expected 001", {seed_load_out, toggle_out, step_out});
      else passed++;
      engine_done();
      checks++;
      if (gen_count_out !== 16'd1) $display("FAIL prio_gen got %0d expected 1", gen_count_out);
      else passed++;
      seed_en_in = 1'b0;
   endtask

   task automatic test_click_drop();
      int ntog;
      do_reset();
      speed_in = 4'd15;
      pulse_frame();
      tick();
      click_in = 1'b1; cursor_x_in = 6'd5; cursor_y_in = 6'd9;
      tick();
      cursor_x_in = 6'd7; cursor_y_in = 6'd7;
      tick();
      click_in = 1'b0;
      engine_done();
      tick();
      checks++;
      if ({toggle_out, toggle_x_out, toggle_y_out} !== {1'b1, 6'd5, 6'd9})
         $display("FAIL drop_first got %b_%0d_%0d expected 1_5_9", toggle_out, toggle_x_out, toggle_y_out);
      else passed++;
      engine_done();
      ntog = 0;
      for (int i = 0; i < 5; i++) begin
         tick(); ntog += int'(toggle_out);
      end
      checks++;
      if (ntog != 0) $display("FAIL drop_extra got %0d expected 0", ntog);
      else passed++;
      click_in = 1'b1;
      tick();
      click_in = 1'b0; cursor_x_in = 6'd1; cursor_y_in = 6'd2;
      tick();
      checks++;
      if ({toggle_out, toggle_x_out, toggle_y_out} !== {1'b1, 6'd7, 6'd7})
         $display("FAIL drop_second got %b_%0d_%0d expected 1_7_7", toggle_out, toggle_x_out, toggle_y_out);
      else passed++;
      engine_done();
   endtask

   task automatic test_seed_hold();
      int nstep;
      int nseed;
      do_reset();
      speed_in = 4'd15;
      pulse_frame();
      tick();
      engine_done();
      seed_en_in = 1'b1; seed_idx_in = 2'd3;
      tick();
      seed_idx_in = 2'd1;
      tick();
      checks++;
      if ({seed_load_out, seed_idx_out} !== 3'b111)
         $display("FAIL seed_start got %b expected 111", {seed_load_out, seed_idx_out});
      else passed++;
      engine_done();
      nstep = 0; nseed = 0;
      for (int i = 0; i < 8; i++) begin
         pulse_frame(); nstep += int'(step_out); nseed += int'(seed_load_out);
         tick();        nstep += int'(step_out); nseed += int'(seed_load_out);
      end
      checks++;
      if ({nstep, nseed} !== {32'd0, 32'd0}) $display("FAIL seed_hold got steps=%0d seeds=%0d expected 0/0", nstep, nseed);
      else passed++;
      checks++;
      if (gen_count_out !== 16'd0) $display("FAIL seed_gen got %0d expected 0", gen_count_out);
      else passed++;
      seed_en_in = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] got;
      do_reset();
      speed_in = 4'd15;
      pulse_frame();
      tick();
      checks++;
      if (busy_out !== 1'b1) $display("FAIL mid_busy got %b expected 1", busy_out);
      else passed++;
      #2;
      rst_in = 1'b1;
      #1;
      got = {step_out, toggle_out, seed_load_out, busy_out};
      checks++;
      if (got !== 4'd0) $display("FAIL mid_async got %b expected 0000", got);
      else passed++;
      tick();
      rst_in = 1'b0;
      speed_in = 4'd0;
      tick();
      engine_done();
      tick();
      got = {step_out, toggle_out, seed_load_out, busy_out};
      checks++;
      if ({got, gen_count_out} !== 20'd0) $display("FAIL mid_late_done got %b gen=%0d expected 0000 gen=0", got, gen_count_out);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_speed_max();
      test_period4();
      test_priority();
      test_click_drop();
      test_seed_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/update_scheduler.md
# update_scheduler

Sequences all writes to the board engine. It sits between `user_interface` and the board update datapath. It turns the speed setting, frame pulses, cell-toggle clicks and seed-load requests into one-at-a-time start pulses with a start/done handshake to the engine. Requests are arbitrated with fixed priority, and the block maintains the generation counter shown on the display.

## Interface
Parameters:
- LOG_MAX_SPEED, 4, width of speed; step period is in frames
- LOG_BOARD_SIZE, 6, width of cell coordinates
- LOG_NUM_SEED, 2, width of seed index
- GEN_WIDTH, 16, width of generation counter

Ports:
- clk_in  input  1  system clock; one clock domain.
- rst_in  input  1  asynchronous, active-high reset.
- frame_in  input  1  one-cycle pulse per video frame
- speed_in  input  LOG_MAX_SPEED  0 = paused, else step rate
- click_in  input  1  one-cycle request to toggle the cell under the cursor
- cursor_x_in, cursor_y_in  input  LOG_BOARD_SIZE  cursor cell
- seed_en_in  input  1  level; seed mode active
- seed_idx_in  input  LOG_NUM_SEED  selected seed pattern
- done_in  input  1  one-cycle engine completion pulse
- step_out  output  1  one-cycle start of a generation step
- toggle_out  output  1  one-cycle start of a cell toggle
- toggle_x_out, toggle_y_out  output  LOG_BOARD_SIZE  captured toggle coordinates
- seed_load_out  output  1  one-cycle start of a seed load
- seed_idx_out  output  LOG_NUM_SEED  captured seed index
- busy_out  output  1  high while an operation is outstanding
- gen_count_out  output  GEN_WIDTH  generations since last seed load/reset

## Operation
- Period P = 2^LOG_MAX_SPEED − speed_in, in frames, range 1..2^LOG_MAX_SPEED−1. Compute it at LOG_MAX_SPEED+1 bits, so there is no wrap.
- Frame counter `fcnt` is LOG_MAX_SPEED bits. It is updated on frame_in only:
  - If speed_in==0 or seed_en_in: fcnt←0 and no step is requested.
  - Else if fcnt+1 ≥ P: fcnt←0 and step_pend←1.
  - Else fcnt←fcnt+1.
- step_pend is already set when a new step fires: the step stays pending as a single step. Steps never queue.
- click_in sets click_pend and captures the cursor into toggle_x/y. If click_pend is already set, the new click is dropped and the coordinates are not overwritten.
- Rising edge of seed_en_in, detected against a registered copy, sets seed_pend and captures seed_idx_in into seed_idx_out.
- FSM states: IDLE, WAIT_SEED, WAIT_TOGGLE, WAIT_STEP.
- In IDLE, the fixed priority is seed_pend > click_pend > step_pend. The winner's start output is pulsed, its pending flag is cleared, and the FSM goes to WAIT_x.
- In WAIT_x:
  - done_in returns the FSM to IDLE.
  - WAIT_STEP done: gen_count += 1, wrapping modulo 2^GEN_WIDTH.
  - WAIT_SEED done: gen_count ← 0.
  - WAIT_TOGGLE done: gen_count unchanged.
- done_in in IDLE is ignored.
- busy_out = (state != IDLE), registered.
- While waiting, requests keep accumulating in their pending flags.

## Timing
- All outputs are registered. Reset values: step_out, toggle_out, seed_load_out, busy_out = 0. toggle_x/y_out, seed_idx_out, gen_count_out = 0. All pending flags, fcnt and seed_en history = 0. State = IDLE.
- Request latency:
  - A request sampled at edge k sets its pending flag at k.
  - If the FSM is in IDLE, the start pulse is high for exactly one cycle after edge k+1.
  - busy_out rises on the same edge as the start pulse.
- Completion: done_in sampled at edge d moves the FSM to IDLE and updates gen_count at d. The next grant pulse can occur at d+1, giving back-to-back operations 1 idle cycle apart.
- At most one start output is high in any cycle. A start output is never issued while busy_out is high.
- Simultaneous events on the same edge:
  - Clear and set of the same pending flag: set wins.
  - click_in and seed edge together: both are latched, and seed is granted first.
- toggle_x/y_out and seed_idx_out stay stable from capture until their operation's done.
- Reset mid-operation: everything returns to reset values immediately (asynchronously). A late done_in from the engine then lands in IDLE and is ignored.

## Test plan
- speed_in=15 (P=1), 4 frame pulses, done_in returned 3 cycles after each step_out → 4 step_out pulses, gen_count_out=4, busy_out high 3 cycles per step.
- speed_in=12 (P=4), 12 frame pulses → step_out exactly on the 4th, 8th and 12th frame. Same run with speed_in=0 → no step_out.
- click_in at cursor (5,9), with step_pend and seed_pend also set in the same cycle → seed_load_out first, then toggle_out with toggle_x/y_out=5/9, then step_out. gen_count_out=1 after the step, because the seed clears it.
- Second click at (7,7) while the first toggle is pending and not yet granted → only one toggle_out, at (5,9). A click at (7,7) after that done → toggle_out at (7,7).
- seed_en_in held high across 8 frames at speed_in=15 → one seed_load_out with seed_idx_out=seed_idx_in at the edge, no step_out, and gen_count_out=0 after done.
- Assert rst_in during WAIT_STEP, then pulse done_in after release → all outputs 0, FSM IDLE, gen_count_out stays 0.
